// File: rtl/load_writeback_unit_pkg.sv
// rtl/load_writeback_unit_pkg.sv - shared state enum and load-size codes for load_writeback_unit
package lwb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    ERROR     = 2'd2
  } lwb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unsupported codes behave as LW, so they are misaligned whenever LW would be.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic result;
    case (funct3)
      F3_LB, F3_LBU: result = 1'b0;
      F3_LH, F3_LHU: result = offset[0];
      default:       result = (offset != 2'b00);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_writeback_unit_load_extend.sv
// rtl/load_writeback_unit_load_extend.sv - byte/half/word lane select with sign or zero extension
module load_extend
  import lwb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = load_data[{offset, 3'b000} +: 8];
  assign half_lane = load_data[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = load_data;
    case (funct3)
      F3_LB:   result = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  result = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_LH:   result = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      F3_LHU:  result = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: result = load_data;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// rtl/load_writeback_unit.sv - load tracking and register write-back; LWB_MISALIGN_CHECK_EN enables misaligned-load trapping
module load_writeback_unit
  import lwb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int REG_SEL_BITS   = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue,
  input  logic                    load,
  input  logic [2:0]              funct3,
  input  logic [REG_SEL_BITS-1:0] rd,
  input  logic                    regWrite,
  input  logic [DATA_WIDTH-1:0]   ALU_Result,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    valid,
  output logic                    write_enable,
  output logic [REG_SEL_BITS-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    stall_req,
  output logic                    timeout_err,
  output logic                    misaligned
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  if (ADDRESS_BITS < 2 || ADDRESS_BITS > DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("load_writeback_unit: unsupported parameter combination");
  end

  lwb_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REG_SEL_BITS-1:0] rd_l_q, rd_l_d;
  logic                    rw_l_q, rw_l_d;
  logic [2:0]              f3_l_q, f3_l_d;
  logic [1:0]              off_l_q, off_l_d;
  logic                    we_q, we_d;
  logic [REG_SEL_BITS-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    tout_q, tout_d;
  logic                    mis_d;
  logic [DATA_WIDTH-1:0]   ext_data;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .load_data (load_data),
    .funct3    (f3_l_q),
    .offset    (off_l_q),
    .result    (ext_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_l_q  <= '0;
      rw_l_q  <= 1'b0;
      f3_l_q  <= '0;
      off_l_q <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_l_q  <= rd_l_d;
      rw_l_q  <= rw_l_d;
      f3_l_q  <= f3_l_d;
      off_l_q <= off_l_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (issue && load) state_d = WAIT_LOAD;
      WAIT_LOAD: begin
        if (valid)                 state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = ERROR;
      end
      ERROR:     state_d = ERROR;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    rd_l_d  = rd_l_q;
    rw_l_d  = rw_l_q;
    f3_l_d  = f3_l_q;
    off_l_d = off_l_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    tout_d  = tout_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue && load) begin
          rd_l_d  = rd;
          rw_l_d  = regWrite;
          f3_l_d  = funct3;
          off_l_d = ALU_Result[1:0];
          cnt_d   = '0;
        end else if (issue) begin
          we_d    = regWrite && (rd != '0);
          wreg_d  = rd;
          wdata_d = ALU_Result;
        end
      end
      WAIT_LOAD: begin
        if (valid) begin
`ifdef LWB_MISALIGN_CHECK_EN
          if (is_misaligned(f3_l_q, off_l_q)) begin
            mis_d = 1'b1;
          end else begin
            we_d    = rw_l_q && (rd_l_q != '0);
            wreg_d  = rd_l_q;
            wdata_d = ext_data;
          end
`else
          we_d    = rw_l_q && (rd_l_q != '0);
          wreg_d  = rd_l_q;
          wdata_d = ext_data;
`endif
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) tout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef LWB_MISALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
  assign misaligned = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_d;
  assign misaligned = 1'b0;
`endif

  assign stall_req    = (state_q == WAIT_LOAD) || (state_q == ERROR);
  assign write_enable = we_q;
  assign write_reg    = wreg_q;
  assign write_data   = wdata_q;
  assign timeout_err  = tout_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// tb/tb_load_writeback_unit.sv - scoreboard bench for load_writeback_unit (TIMEOUT_CYCLES=4)
module tb_load_writeback_unit;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [4:0]  rd = '0;
  logic        regWrite = 1'b0;
  logic [31:0] ALU_Result = '0;
  logic [31:0] load_data = '0;
  logic        valid = 1'b0;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        stall_req;
  logic        timeout_err;
  logic        misaligned;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  load_writeback_unit #(
    .DATA_WIDTH(32), .ADDRESS_BITS(20), .REG_SEL_BITS(5), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .issue(issue), .load(load), .funct3(funct3),
    .rd(rd), .regWrite(regWrite), .ALU_Result(ALU_Result), .load_data(load_data),
    .valid(valid), .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .stall_req(stall_req), .timeout_err(timeout_err),
    .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues a load, waits k cycles, presents valid on the k-th; returns cycles with stall high.
  task automatic run_load(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int k, output int stalls);
    stalls = 0;
    issue = 1'b1; load = 1'b1; rd = r; funct3 = f3; regWrite = 1'b1; ALU_Result = addr;
    tick();
    issue = 1'b0; load = 1'b0;
    for (int i = 1; i < k; i++) begin
      if (stall_req === 1'b1) stalls++;
      tick();
    end
    valid = 1'b1; load_data = data;
    if (stall_req === 1'b1) stalls++;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    total++;
    if ({write_enable, write_reg, write_data, stall_req, timeout_err, misaligned} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got we=%0b reg=%0d data=%h stall=%0b tout=%0b mis=%0b want all 0",
               write_enable, write_reg, write_data, stall_req, timeout_err, misaligned);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_op();
    exp_t e;
    issue = 1'b1; load = 1'b0; rd = 5'd7; regWrite = 1'b1; ALU_Result = 32'h1234;
    sb.push_back('{5'd7, 32'h0000_1234});
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL alu_stall_pre got=%0b want=0", stall_req); end
    tick();
    issue = 1'b0;
    total++;
    if (write_enable !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL alu_we got=%0b want=1", write_enable);
    end else begin
      e = sb.pop_front();
      if (write_reg !== e.r || write_data !== e.d) begin
        bad++; $display("FAIL alu_write got reg=%0d data=%h want reg=%0d data=%h", write_reg, write_data, e.r, e.d);
      end
    end
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b want=0", stall_req); end
    tick();
    total++;
    if (write_enable !== 1'b0) begin bad++; $display("FAIL alu_we_pulse got=%0b want=0", write_enable); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0]  rds[4]  = '{5'd1, 5'd0, 5'd2, 5'd4};
    logic        rws[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] vals[4] = '{32'hA5A5_0001, 32'hDEAD_0000, 32'h0BAD_0002, 32'hC0DE_0004};
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1; load = 1'b0; rd = rds[i]; regWrite = rws[i]; ALU_Result = vals[i];
      if (rws[i] && rds[i] != 5'd0) sb.push_back('{rds[i], vals[i]});
      tick();
      total++;
      if (rws[i] && rds[i] != 5'd0) begin
        if (write_enable !== 1'b1 || sb.size() == 0) begin
          bad++; $display("FAIL b2b_we[%0d] got=%0b want=1", i, write_enable);
        end else begin
          e = sb.pop_front();
          if (write_reg !== e.r || write_data !== e.d) begin
            bad++; $display("FAIL b2b_write[%0d] got reg=%0d data=%h want reg=%0d data=%h",
                            i, write_reg, write_data, e.r, e.d);
          end
        end
      end else if (write_enable !== 1'b0) begin
        bad++; $display("FAIL b2b_suppress[%0d] got we=%0b want=0", i, write_enable);
      end
    end
    issue = 1'b0;
    tick();
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int k, input logic [31:0] want);
    exp_t e;
    int stalls;
    sb.push_back('{5'd5, want});
    run_load(5'd5, f3, addr, data, k, stalls);
    total++;
    if (stalls != k) begin bad++; $display("FAIL %s_stall_cycles got=%0d want=%0d", name, stalls, k); end
    total++;
    if (write_enable !== 1'b1 || sb.size() == 0) begin
      bad++; $display("FAIL %s_we got=%0b want=1", name, write_enable);
    end else begin
      e = sb.pop_front();
      if (write_reg !== e.r || write_data !== e.d) begin
        bad++; $display("FAIL %s_write got reg=%0d data=%h want reg=%0d data=%h",
                        name, write_reg, write_data, e.r, e.d);
      end
    end
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL %s_stall_after got=%0b want=0", name, stall_req); end
  endtask

  task automatic test_idle_valid();
    valid = 1'b1; load_data = 32'hFFFF_FFFF;
    tick();
    valid = 1'b0;
    total++;
    if (write_enable !== 1'b0 || stall_req !== 1'b0) begin
      bad++; $display("FAIL idle_valid got we=%0b stall=%0b want 0 0", write_enable, stall_req);
    end
  endtask

  task automatic test_timeout();
    issue = 1'b1; load = 1'b1; rd = 5'd3; funct3 = 3'b010; regWrite = 1'b1; ALU_Result = 32'h40;
    tick();
    issue = 1'b0; load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (timeout_err !== (i == 4) || write_enable !== 1'b0 || stall_req !== 1'b1) begin
        bad++; $display("FAIL timeout_wait[%0d] got tout=%0b we=%0b stall=%0b want tout=%0b we=0 stall=1",
                        i, timeout_err, write_enable, stall_req, (i == 4));
      end
    end
    issue = 1'b1; load = 1'b0; rd = 5'd6; ALU_Result = 32'h99; valid = 1'b1;
    tick(); tick();
    issue = 1'b0; valid = 1'b0;
    total++;
    if (timeout_err !== 1'b1 || stall_req !== 1'b1 || write_enable !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky got tout=%0b stall=%0b we=%0b want 1 1 0", timeout_err, stall_req, write_enable);
    end
    reset = 1'b0;
    #1;
    total++;
    if (timeout_err !== 1'b0 || stall_req !== 1'b0) begin
      bad++; $display("FAIL timeout_reset got tout=%0b stall=%0b want 0 0", timeout_err, stall_req);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_load();
    issue = 1'b1; load = 1'b1; rd = 5'd12; funct3 = 3'b010; regWrite = 1'b1; ALU_Result = 32'h80;
    tick();
    issue = 1'b0; load = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    valid = 1'b1; load_data = 32'h7777_7777;
    tick();
    valid = 1'b0;
    total++;
    if ({write_enable, write_reg, write_data, stall_req, timeout_err, misaligned} !== '0) begin
      bad++;
      $display("FAIL reset_mid_load got we=%0b reg=%0d data=%h stall=%0b tout=%0b mis=%0b want all 0",
               write_enable, write_reg, write_data, stall_req, timeout_err, misaligned);
    end
  endtask

  task automatic test_misalign();
    int stalls;
`ifdef LWB_MISALIGN_CHECK_EN
    run_load(5'd9, 3'b010, 32'h1, 32'hDEAD_BEEF, 1, stalls);
    total++;
    if (misaligned !== 1'b1 || write_enable !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse got mis=%0b we=%0b want 1 0", misaligned, write_enable);
    end
    tick();
    total++;
    if (misaligned !== 1'b0 || stall_req !== 1'b0) begin
      bad++; $display("FAIL misalign_clear got mis=%0b stall=%0b want 0 0", misaligned, stall_req);
    end
`else
    exp_t e;
    sb.push_back('{5'd9, 32'hDEAD_BEEF});
    run_load(5'd9, 3'b010, 32'h1, 32'hDEAD_BEEF, 1, stalls);
    total++;
    if (write_enable !== 1'b1 || misaligned !== 1'b0 || sb.size() == 0) begin
      bad++; $display("FAIL misalign_off got we=%0b mis=%0b want 1 0", write_enable, misaligned);
    end else begin
      e = sb.pop_front();
      if (write_reg !== e.r || write_data !== e.d) begin
        bad++; $display("FAIL misalign_off_write got reg=%0d data=%h want reg=%0d data=%h",
                        write_reg, write_data, e.r, e.d);
      end
    end
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_load("lb", 3'b000, 32'h0000_0003, 32'h80FF_1122, 3, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h0000_0001, 32'h80FF_1122, 1, 32'h0000_0011);
    test_load("lhu", 3'b101, 32'h0000_0002, 32'hBEEF_0000, 2, 32'h0000_BEEF);
    test_load("lh", 3'b001, 32'h0000_0002, 32'hBEEF_0000, 2, 32'hFFFF_BEEF);
    test_load("lw_edge", 3'b010, 32'h0000_0010, 32'h1234_5678, 4, 32'h1234_5678);
    test_load("bad_f3", 3'b111, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    test_idle_valid();
    test_misalign();
    test_timeout();
    test_reset_mid_load();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
